// File: rtl/indirect_access_ctrl.sv
// Indirect register window: ADDR/DATA/CTRL host registers driving a
// request/acknowledge target port with auto-increment, prefetch and watchdog.
module indirect_access_ctrl #(
   parameter int         ADDR_BITS       = 32,
   parameter int         DATA_BITS       = 32,
   parameter int         BE_BITS         = DATA_BITS / 8,
   parameter logic [7:0] REG_ADDR_OFFSET = 8'h0,
   parameter logic [7:0] REG_DATA_OFFSET = 8'h4,
   parameter logic [7:0] REG_CTRL_OFFSET = 8'h8,
   parameter int         ADDR_STEP       = 1,
   parameter int         TIMEOUT_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_din,
   input  logic [BE_BITS-1:0]   wr_be,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] rd_addr,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_dout,
   output logic [DATA_BITS-1:0] ind_addr,
   output logic                 ind_req,
   output logic                 ind_we,
   output logic [DATA_BITS-1:0] ind_dout,
   input  logic [DATA_BITS-1:0] ind_din,
   input  logic                 ind_ack
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [DATA_BITS-1:0] STEP = DATA_BITS'(ADDR_STEP);
   localparam logic [TIMEOUT_BITS-1:0] WD_LAST =
      {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

   state_t                  state;
   logic [DATA_BITS-1:0]    addr_q;
   logic [DATA_BITS-1:0]    wdata_q;
   logic [DATA_BITS-1:0]    rdata_q;
   logic                    autoinc_q;
   logic                    prefetch_q;
   logic                    tout_q;
   logic                    ovr_q;
   logic                    rvalid_q;
   logic [TIMEOUT_BITS-1:0] wd_cnt;

   logic                 busy;
   logic                 aw_hit, dw_hit, cw_hit;
   logic                 ar_hit, dr_hit, cr_hit;
   logic                 aw_pf, dr_go;
   logic                 ctl_lo, ctl_hi;
   logic                 ovr_set, tout_set;
   logic                 ovr_clr, tout_clr;
   logic [DATA_BITS-1:0] addr_wr, wdata_wr;
   logic [DATA_BITS-1:0] addr_new, dr_addr;
   logic [DATA_BITS-1:0] status;

   function automatic logic [DATA_BITS-1:0] merge(
      input logic [DATA_BITS-1:0] old_v,
      input logic [DATA_BITS-1:0] new_v,
      input logic [BE_BITS-1:0]   be
   );
      logic [DATA_BITS-1:0] m;
      m = old_v;
      for (int i = 0; i < BE_BITS; i++)
         if (be[i]) m[i*8 +: 8] = new_v[i*8 +: 8];
      return m;
   endfunction

   assign busy   = (state != IDLE);
   assign aw_hit = wr_en && (wr_addr == ADDR_BITS'(REG_ADDR_OFFSET));
   assign dw_hit = wr_en && (wr_addr == ADDR_BITS'(REG_DATA_OFFSET));
   assign cw_hit = wr_en && (wr_addr == ADDR_BITS'(REG_CTRL_OFFSET));
   assign ar_hit = rd_en && (rd_addr == ADDR_BITS'(REG_ADDR_OFFSET));
   assign dr_hit = rd_en && (rd_addr == ADDR_BITS'(REG_DATA_OFFSET));
   assign cr_hit = rd_en && (rd_addr == ADDR_BITS'(REG_CTRL_OFFSET));

   always_comb begin
      addr_wr  = merge(addr_q, wr_din, wr_be);
      wdata_wr = merge(wdata_q, wr_din, wr_be);
      addr_new = aw_hit ? addr_wr : addr_q;
      dr_addr  = autoinc_q ? addr_q + STEP : addr_q;
      // any same-cycle ADDR/DATA write takes priority over a DATA read
      aw_pf    = aw_hit && prefetch_q && !dw_hit;
      dr_go    = dr_hit && !dw_hit && !aw_hit;
      ctl_lo   = cw_hit && wr_be[0];
      ctl_hi   = cw_hit && wr_be[1];
      tout_clr = ctl_hi && wr_din[9];
      ovr_clr  = ctl_hi && wr_din[10];
      ovr_set  = (busy && (aw_hit || dw_hit || dr_hit)) ||
                 (!busy && dr_hit && (dw_hit || aw_hit));
      tout_set = (state == REQ) && !ind_ack && (wd_cnt == WD_LAST);
      status     = '0;
      status[0]  = autoinc_q;
      status[1]  = prefetch_q;
      status[8]  = busy;
      status[9]  = tout_q;
      status[10] = ovr_q;
      status[11] = rvalid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         autoinc_q  <= 1'b0;
         prefetch_q <= 1'b0;
         tout_q     <= 1'b0;
         ovr_q      <= 1'b0;
         rvalid_q   <= 1'b0;
         wd_cnt     <= '0;
         rd_dout    <= '0;
         ind_addr   <= '0;
         ind_req    <= 1'b0;
         ind_we     <= 1'b0;
         ind_dout   <= '0;
      end else begin
         unique case (1'b1)
            ar_hit:  rd_dout <= addr_q;
            dr_hit:  rd_dout <= rdata_q;
            cr_hit:  rd_dout <= status;
            default: rd_dout <= '0;
         endcase
         if (ctl_lo) begin
            autoinc_q  <= wr_din[0];
            prefetch_q <= wr_din[1];
         end
         ovr_q  <= ovr_set  | (ovr_q  & ~ovr_clr);
         tout_q <= tout_set | (tout_q & ~tout_clr);
         unique case (state)
            IDLE: begin
               wd_cnt <= '0;
               if (aw_hit) addr_q <= addr_wr;
               if (dw_hit) begin
                  wdata_q  <= wdata_wr;
                  ind_req  <= 1'b1;
                  ind_we   <= 1'b1;
                  ind_addr <= addr_new;
                  ind_dout <= wdata_wr;
                  state    <= REQ;
               end else if (aw_pf) begin
                  ind_req  <= 1'b1;
                  ind_we   <= 1'b0;
                  ind_addr <= addr_wr;
                  rvalid_q <= 1'b0;
                  state    <= REQ;
               end else if (dr_go) begin
                  addr_q <= dr_addr;
                  if (prefetch_q) begin
                     ind_req  <= 1'b1;
                     ind_we   <= 1'b0;
                     ind_addr <= dr_addr;
                     rvalid_q <= 1'b0;
                     state    <= REQ;
                  end
               end
            end
            REQ: begin
               if (ind_ack) begin
                  ind_req <= 1'b0;
                  state   <= DONE;
                  if (!ind_we) begin
                     rdata_q  <= ind_din;
                     rvalid_q <= 1'b1;
                  end
               end else if (wd_cnt == WD_LAST) begin
                  ind_req <= 1'b0;
                  state   <= DONE;
                  if (!ind_we) begin
                     rdata_q  <= '1;
                     rvalid_q <= 1'b1;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               if (ind_we && autoinc_q) addr_q <= addr_q + STEP;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
